// File: rtl/parking_gate_counter_if.sv
// Sensor inputs and occupancy/pulse outputs of the parking gate counter.
// The slave side is the counter; the master side drives the sensors.
interface parking_gate_counter_if #(
   parameter int NUM_GATES = 2,
   parameter int CNT_W     = 5,
   parameter int TOT_W     = 16
);
   logic [NUM_GATES-1:0] sens_a;
   logic [NUM_GATES-1:0] sens_b;
   logic [NUM_GATES-1:0] enter_pulse;
   logic [NUM_GATES-1:0] exit_pulse;
   logic                 reject_pulse;
   logic [CNT_W-1:0]     count;
   logic                 full;
   logic                 empty;
   logic [TOT_W-1:0]     total_in;

   modport master (
      output sens_a,
      output sens_b,
      input  enter_pulse,
      input  exit_pulse,
      input  reject_pulse,
      input  count,
      input  full,
      input  empty,
      input  total_in
   );

   modport slave (
      input  sens_a,
      input  sens_b,
      output enter_pulse,
      output exit_pulse,
      output reject_pulse,
      output count,
      output full,
      output empty,
      output total_in
   );
endinterface

// File: rtl/parking_gate_counter.sv
// Multi-gate parking occupancy counter: per-gate direction FSMs feeding
// a saturating arbiter that merges same-cycle entries and exits.
module parking_gate_counter #(
   parameter int NUM_GATES = 2,
   parameter int CAPACITY  = 16,
   parameter int CNT_W     = $clog2(CAPACITY + 1),
   parameter int TOT_W     = 16
) (
   input  logic                  clk,
   input  logic                  reset,
   parking_gate_counter_if.slave bus
);
   localparam int GW = $clog2(NUM_GATES + 1);
   localparam int SW = ((CNT_W > GW) ? CNT_W : GW) + 1;

   typedef enum logic [2:0] {
      IDLE,
      E1,
      E2,
      E3,
      X1,
      X2,
      X3
   } gate_state_e;

   gate_state_e state_q [NUM_GATES];
   gate_state_e state_d [NUM_GATES];

   logic [NUM_GATES-1:0] ent_done;
   logic [NUM_GATES-1:0] ext_done;
   logic [NUM_GATES-1:0] granted;
   logic                 rejected;

   logic [SW-1:0]    n_exit;
   logic [SW-1:0]    after_exit;
   logic [SW-1:0]    room;
   logic [SW-1:0]    n_acc;
   logic [CNT_W-1:0] count_d;
   logic [CNT_W-1:0] count_q;
   logic [TOT_W-1:0] total_q;

   logic [NUM_GATES-1:0] enter_q;
   logic [NUM_GATES-1:0] exit_q;
   logic                 reject_q;

   // Sensor pair is {a,b}; the exit path mirrors entry with a/b swapped.
   function automatic gate_state_e next_state(
      input gate_state_e s,
      input logic [1:0]  ab
   );
      next_state = s;
      unique case (s)
         IDLE: begin
            if (ab == 2'b10)      next_state = E1;
            else if (ab == 2'b01) next_state = X1;
         end
         E1: begin
            if (ab == 2'b11)      next_state = E2;
            else if (ab != 2'b10) next_state = IDLE;
         end
         E2: begin
            if (ab == 2'b01)      next_state = E3;
            else if (ab == 2'b10) next_state = E1;
            else if (ab == 2'b00) next_state = IDLE;
         end
         E3: begin
            if (ab == 2'b11)      next_state = E2;
            else if (ab != 2'b01) next_state = IDLE;
         end
         X1: begin
            if (ab == 2'b11)      next_state = X2;
            else if (ab != 2'b01) next_state = IDLE;
         end
         X2: begin
            if (ab == 2'b10)      next_state = X3;
            else if (ab == 2'b01) next_state = X1;
            else if (ab == 2'b00) next_state = IDLE;
         end
         X3: begin
            if (ab == 2'b11)      next_state = X2;
            else if (ab != 2'b10) next_state = IDLE;
         end
         default: next_state = IDLE;
      endcase
   endfunction

   always_comb begin
      ent_done = '0;
      ext_done = '0;
      for (int g = 0; g < NUM_GATES; g++) begin
         state_d[g] = next_state(state_q[g],
                                 {bus.sens_a[g], bus.sens_b[g]});
         ent_done[g] = (state_q[g] == E3) &&
                       !bus.sens_a[g] && !bus.sens_b[g];
         ext_done[g] = (state_q[g] == X3) &&
                       !bus.sens_a[g] && !bus.sens_b[g];
      end
   end

   always_ff @(posedge clk) begin
      for (int g = 0; g < NUM_GATES; g++) begin
         if (reset) state_q[g] <= IDLE;
         else       state_q[g] <= state_d[g];
      end
   end

   // Exits drain first so a simultaneous exit frees room for an entry.
   always_comb begin
      n_exit = '0;
      for (int g = 0; g < NUM_GATES; g++)
         n_exit = n_exit + SW'(ext_done[g]);

      after_exit = (SW'(count_q) > n_exit) ?
                   (SW'(count_q) - n_exit) : '0;
      room = SW'(CAPACITY) - after_exit;

      granted  = '0;
      rejected = 1'b0;
      n_acc    = '0;
      for (int g = 0; g < NUM_GATES; g++) begin
         if (ent_done[g]) begin
            if (n_acc < room) begin
               granted[g] = 1'b1;
               n_acc      = n_acc + 1'b1;
            end else begin
               rejected = 1'b1;
            end
         end
      end
      count_d = CNT_W'(after_exit + n_acc);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         count_q  <= '0;
         total_q  <= '0;
         enter_q  <= '0;
         exit_q   <= '0;
         reject_q <= 1'b0;
      end else begin
         count_q  <= count_d;
         total_q  <= total_q + TOT_W'(n_acc);
         enter_q  <= granted;
         exit_q   <= ext_done;
         reject_q <= rejected;
      end
   end

   assign bus.enter_pulse  = enter_q;
   assign bus.exit_pulse   = exit_q;
   assign bus.reject_pulse = reject_q;
   assign bus.count        = count_q;
   assign bus.total_in     = total_q;
   assign bus.full         = (count_q == CNT_W'(CAPACITY));
   assign bus.empty        = (count_q == '0);

endmodule
